uart_tx: RTL and testbench

- UART transmitter. Serialises one parallel byte per request into an asynchronous frame: start bit, data bits LSB first, optional parity, stop bit(s).
- Bit timing comes from an external oversampling tick, s_tick, driven by the baud-rate mod-m counter at 16x the baud rate.
- Sits between the TX FIFO or host logic and the serial pin. It is the transmit counterpart of the UART receiver.

---
 rtl/uart_tx.sv | 150 +++++++++++++++
 tb/tb_uart_tx.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: serialises one byte per request into
// start bit, DBIT data bits (LSB first), optional parity bit and stop period.
// Bit timing comes from a 16x oversampling enable (s_tick); each bit is 16 ticks.
module uart_tx #(
  parameter int DBIT    = 8,   // data bits per frame, 5..8
  parameter int SB_TICK = 16,  // ticks in the stop period, 16..32
  parameter int PARITY  = 0    // 0 none, 1 even, 2 odd
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx_busy,
  output logic       tx_done_tick,
  output logic       tx
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // Last tick index of a bit / of the stop period, and last data bit index.
  localparam logic [4:0] BIT_LAST  = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);
  // Odd parity starts the accumulator at 1 so the XOR of the data lands on odd.
  localparam logic       P_INIT    = (PARITY == 2) ? 1'b1 : 1'b0;

  state_t     state_reg, state_next;
  logic [4:0] s_reg, s_next;
  logic [2:0] n_reg, n_next;
  logic [7:0] b_reg, b_next;
  logic       p_reg, p_next;
  logic       tx_reg, tx_next;

  // State and datapath registers; reset drops the frame immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      s_reg     <= 5'd0;
      n_reg     <= 3'd0;
      b_reg     <= 8'd0;
      p_reg     <= 1'b0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      p_reg     <= p_next;
      tx_reg    <= tx_next;
    end
  end

  // Next-state logic; the line level is derived from the next state so tx
  // moves on the same edge as the state it belongs to.
  always_comb begin
    state_next   = state_reg;
    s_next       = s_reg;
    n_next       = n_reg;
    b_next       = b_reg;
    p_next       = p_reg;
    tx_done_tick = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // s_tick is irrelevant here; only a request moves us on.
        if (tx_start) begin
          state_next = ST_START;
          s_next     = 5'd0;
          b_next     = din;
          p_next     = P_INIT;
        end
      end

      ST_START: begin
        if (s_tick) begin
          if (s_reg == BIT_LAST) begin
            state_next = ST_DATA;
            s_next     = 5'd0;
            n_next     = 3'd0;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end

      ST_DATA: begin
        if (s_tick) begin
          if (s_reg == BIT_LAST) begin
            s_next = 5'd0;
            p_next = p_reg ^ b_reg[0];
            b_next = {1'b0, b_reg[7:1]};
            if (n_reg == N_LAST) begin
              state_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
            end else begin
              n_next = n_reg + 3'd1;
            end
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end

      ST_PARITY: begin
        if (s_tick) begin
          if (s_reg == BIT_LAST) begin
            state_next = ST_STOP;
            s_next     = 5'd0;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end

      ST_STOP: begin
        // The done pulse marks the final clk of the frame; the request input
        // is not looked at in this state, so a new frame waits one idle clk.
        if (s_tick) begin
          if (s_reg == STOP_LAST) begin
            state_next   = ST_IDLE;
            tx_done_tick = 1'b1;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = b_next[0];
      ST_PARITY: tx_next = p_next;
      default:   tx_next = 1'b1;
    endcase
  end

  assign tx_busy = (state_reg != ST_IDLE);
  assign tx      = tx_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx: five instances cover the default build,
// even/odd parity, a 2-stop-bit build and a 7-data-bit build.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_tick = 1'b0;
  logic [7:0] din = 8'h00;
  logic [4:0] start_v = 5'b0;
  wire  [4:0] tx_w;
  wire  [4:0] busy_w;
  wire  [4:0] done_w;

  int tick_div = 0;
  int tick_cnt = 0;
  int n_checks = 0;
  int n_pass = 0;
  logic [4:0] cur_mask = 5'b0;

  logic [4:0] tx_s   [0:1023];
  logic [4:0] busy_s [0:1023];
  logic [4:0] done_s [0:1023];

  always #5 clk = ~clk;

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u_def (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start_v[0]), .din(din),
    .tx_busy(busy_w[0]), .tx_done_tick(done_w[0]), .tx(tx_w[0]));
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u_even (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start_v[1]), .din(din),
    .tx_busy(busy_w[1]), .tx_done_tick(done_w[1]), .tx(tx_w[1]));
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u_odd (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start_v[2]), .din(din),
    .tx_busy(busy_w[2]), .tx_done_tick(done_w[2]), .tx(tx_w[2]));
  uart_tx #(.DBIT(8), .SB_TICK(32), .PARITY(0)) u_sb32 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start_v[3]), .din(din),
    .tx_busy(busy_w[3]), .tx_done_tick(done_w[3]), .tx(tx_w[3]));
  uart_tx #(.DBIT(7), .SB_TICK(16), .PARITY(0)) u_d7 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start_v[4]), .din(din),
    .tx_busy(busy_w[4]), .tx_done_tick(done_w[4]), .tx(tx_w[4]));

  // Advance one clk: inputs change just after the falling edge, outputs are
  // read 1 ns later (well away from the rising edge).
  task automatic step();
    @(negedge clk);
    if (tick_div > 0) begin
      tick_cnt = (tick_cnt + 1) % tick_div;
      s_tick = (tick_cnt == 0);
    end else begin
      s_tick = 1'b0;
    end
    #1;
  endtask

  task automatic set_tick(int div);
    tick_div = div;
    tick_cnt = 0;
    s_tick = (div > 0);
  endtask

  // Pulse (or hold) tx_start on the DUTs in mask, aligned to a cycle with
  // s_tick high so that bit boundaries fall exactly every 16 ticks.
  task automatic launch(logic [4:0] mask, logic [7:0] data, bit hold);
    int w;
    w = 0;
    while (!s_tick && w < 8) begin
      step();
      w++;
    end
    if (!s_tick) begin
      n_checks++;
      $display("FAIL launch_align: s_tick=%b required 1", s_tick);
    end
    din = data;
    cur_mask = mask;
    start_v = mask;
    step();
    if (!hold) start_v = 5'b0;
    $display("frame: dut_mask=%b din=%h hold=%0d tick_div=%0d", mask, data, hold, tick_div);
  endtask

  // Record n cycles of outputs; at inj_a/inj_b pulse tx_start with din=FF.
  task automatic capture(int n, int inj_a, int inj_b);
    for (int i = 0; i < n; i++) begin
      tx_s[i] = tx_w;
      busy_s[i] = busy_w;
      done_s[i] = done_w;
      if (i == inj_a || i == inj_b) begin
        start_v = start_v | cur_mask;
        din = 8'hFF;
      end else if ((inj_a >= 0 && i == inj_a + 1) || (inj_b >= 0 && i == inj_b + 1)) begin
        start_v = 5'b0;
      end
      step();
    end
  endtask

  // First recorded cycle in [from, from+len) where tx of DUT k differs from val.
  function automatic int tx_bad(int k, int from, int len, logic val);
    for (int i = from; i < from + len; i++)
      if (tx_s[i][k] !== val) return i;
    return -1;
  endfunction

  // First cycle where tx of DUT k departs from a frame with bitlen-clk bits
  // (the last bit lasting lastlen clk); exp holds bits first-sent at index 0.
  function automatic int frame_bad(int k, int base, int nbits, logic [0:15] exp,
                                   int bitlen, int lastlen);
    int r;
    for (int b = 0; b < nbits; b++) begin
      r = tx_bad(k, base + b * bitlen, (b == nbits - 1) ? lastlen : bitlen, exp[b]);
      if (r >= 0) return r;
    end
    return -1;
  endfunction

  function automatic int busy_bad(int k, int from, int len, logic val);
    for (int i = from; i < from + len; i++)
      if (busy_s[i][k] !== val) return i;
    return -1;
  endfunction

  function automatic int done_count(int k, int from, int len);
    int c;
    c = 0;
    for (int i = from; i < from + len; i++)
      if (done_s[i][k] !== 1'b0) c++;
    return c;
  endfunction

  task automatic test_reset();
    int bad;
    step(); step(); step();
    n_checks++;
    if (tx_w !== 5'h1F) $display("FAIL reset_tx: got %b want 11111", tx_w); else n_pass++;
    n_checks++;
    if (busy_w !== 5'h00) $display("FAIL reset_busy: got %b want 00000", busy_w); else n_pass++;
    n_checks++;
    if (done_w !== 5'h00) $display("FAIL reset_done: got %b want 00000", done_w); else n_pass++;
    reset = 1'b1;
    set_tick(4);
    capture(40, -1, -1);
    bad = -1;
    for (int i = 0; i < 40; i++)
      if (bad < 0 && (tx_s[i] !== 5'h1F || busy_s[i] !== 5'h00 || done_s[i] !== 5'h00)) bad = i;
    n_checks++;
    if (bad >= 0)
      $display("FAIL idle_after_reset: cycle %0d tx=%b busy=%b done=%b want 11111/00000/00000",
               bad, tx_s[bad], busy_s[bad], done_s[bad]);
    else n_pass++;
  endtask

  task automatic test_default_frame();
    logic [0:9] exp;
    int bad;
    exp = 10'b0101001011;  // 0xA5: start, 1,0,1,0,0,1,0,1, stop
    set_tick(4);
    launch(5'b00001, 8'hA5, 1'b0);
    capture(641, -1, -1);
    for (int b = 0; b < 10; b++) begin
      bad = tx_bad(0, b * 64, 64, exp[b]);
      n_checks++;
      if (bad >= 0) $display("FAIL a5_bit%0d: cycle %0d tx=%b want %b", b, bad, tx_s[bad][0], exp[b]);
      else n_pass++;
    end
    bad = busy_bad(0, 0, 640, 1'b1);
    n_checks++;
    if (bad >= 0) $display("FAIL a5_busy: cycle %0d busy=0 want 1", bad); else n_pass++;
    n_checks++;
    if (done_count(0, 0, 641) != 1) $display("FAIL a5_done_count: got %0d want 1", done_count(0, 0, 641));
    else n_pass++;
    n_checks++;
    if (done_s[639][0] !== 1'b1) $display("FAIL a5_done_cycle639: got %b want 1", done_s[639][0]);
    else n_pass++;
    n_checks++;
    if (tx_s[640][0] !== 1'b1 || busy_s[640][0] !== 1'b0)
      $display("FAIL a5_idle_after: tx=%b busy=%b want 1/0", tx_s[640][0], busy_s[640][0]);
    else n_pass++;
  endtask

  task automatic test_ignore_start();
    int bad;
    set_tick(1);
    launch(5'b00001, 8'hA5, 1'b0);
    capture(163, 50, 159);  // mid-frame request and one in the done cycle
    bad = frame_bad(0, 0, 10, {10'b0101001011, 6'b0}, 16, 16);
    n_checks++;
    if (bad >= 0) $display("FAIL ignore_frame: cycle %0d tx=%b", bad, tx_s[bad][0]); else n_pass++;
    n_checks++;
    if (done_s[159][0] !== 1'b1 || done_count(0, 0, 163) != 1)
      $display("FAIL ignore_done: done@159=%b count=%0d want 1/1", done_s[159][0], done_count(0, 0, 163));
    else n_pass++;
    bad = busy_bad(0, 160, 3, 1'b0);
    n_checks++;
    if (bad >= 0 || tx_bad(0, 160, 3, 1'b1) >= 0)
      $display("FAIL ignore_in_done_cycle: busy=%b tx=%b at 160 want 0/1", busy_s[160][0], tx_s[160][0]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int bad;
    logic [0:15] exp;
    exp = {10'b0010110101, 6'b0};  // 0x5A
    set_tick(1);
    launch(5'b00001, 8'h5A, 1'b1);
    capture(322, 170, -1);  // din -> FF after the second acceptance
    bad = frame_bad(0, 0, 10, exp, 16, 16);
    n_checks++;
    if (bad >= 0) $display("FAIL b2b_frame1: cycle %0d tx=%b", bad, tx_s[bad][0]); else n_pass++;
    n_checks++;
    if (done_s[159][0] !== 1'b1) $display("FAIL b2b_done1: got %b want 1", done_s[159][0]); else n_pass++;
    n_checks++;
    if (tx_s[160][0] !== 1'b1 || busy_s[160][0] !== 1'b0)
      $display("FAIL b2b_gap: tx=%b busy=%b want 1/0", tx_s[160][0], busy_s[160][0]);
    else n_pass++;
    n_checks++;
    if (tx_s[161][0] !== 1'b0 || busy_s[161][0] !== 1'b1)
      $display("FAIL b2b_start2: tx=%b busy=%b want 0/1", tx_s[161][0], busy_s[161][0]);
    else n_pass++;
    bad = frame_bad(0, 161, 10, exp, 16, 16);
    n_checks++;
    if (bad >= 0) $display("FAIL b2b_frame2: cycle %0d tx=%b", bad, tx_s[bad][0]); else n_pass++;
    n_checks++;
    if (done_s[320][0] !== 1'b1 || done_count(0, 0, 322) != 2)
      $display("FAIL b2b_done2: done@320=%b count=%0d want 1/2", done_s[320][0], done_count(0, 0, 322));
    else n_pass++;
  endtask

  task automatic test_parity();
    int bad;
    set_tick(1);
    launch(5'b00110, 8'h07, 1'b0);
    capture(177, -1, -1);
    bad = frame_bad(1, 0, 11, {11'b01110000011, 5'b0}, 16, 16);
    n_checks++;
    if (bad >= 0) $display("FAIL even_frame: cycle %0d tx=%b", bad, tx_s[bad][1]); else n_pass++;
    bad = frame_bad(2, 0, 11, {11'b01110000001, 5'b0}, 16, 16);
    n_checks++;
    if (bad >= 0) $display("FAIL odd_frame: cycle %0d tx=%b", bad, tx_s[bad][2]); else n_pass++;
    n_checks++;
    if (tx_s[152][1] !== 1'b1) $display("FAIL even_parity_bit: got %b want 1", tx_s[152][1]); else n_pass++;
    n_checks++;
    if (tx_s[152][2] !== 1'b0) $display("FAIL odd_parity_bit: got %b want 0", tx_s[152][2]); else n_pass++;
    n_checks++;
    if (done_s[175][2:1] !== 2'b11 || done_count(1, 0, 177) != 1)
      $display("FAIL parity_done: done@175=%b want 11", done_s[175][2:1]);
    else n_pass++;
    n_checks++;
    if (busy_s[176][2:1] !== 2'b00 || busy_s[175][2:1] !== 2'b11)
      $display("FAIL parity_length: busy@175=%b busy@176=%b want 11/00", busy_s[175][2:1], busy_s[176][2:1]);
    else n_pass++;
  endtask

  task automatic test_sb32_dbit7();
    int bad;
    set_tick(1);
    launch(5'b01000, 8'h3C, 1'b0);
    capture(178, -1, -1);
    bad = frame_bad(3, 0, 10, {10'b0001111001, 6'b0}, 16, 32);
    n_checks++;
    if (bad >= 0) $display("FAIL sb32_frame: cycle %0d tx=%b", bad, tx_s[bad][3]); else n_pass++;
    n_checks++;
    if (done_s[175][3] !== 1'b1 || done_count(3, 0, 178) != 1)
      $display("FAIL sb32_done: done@175=%b count=%0d want 1/1", done_s[175][3], done_count(3, 0, 178));
    else n_pass++;
    n_checks++;
    if (busy_s[176][3] !== 1'b0) $display("FAIL sb32_idle: busy@176=%b want 0", busy_s[176][3]); else n_pass++;

    launch(5'b10000, 8'h80, 1'b0);
    capture(146, -1, -1);
    bad = frame_bad(4, 0, 9, {9'b000000001, 7'b0}, 16, 16);
    n_checks++;
    if (bad >= 0) $display("FAIL d7_frame: cycle %0d tx=%b", bad, tx_s[bad][4]); else n_pass++;
    n_checks++;
    if (done_s[143][4] !== 1'b1 || done_count(4, 0, 146) != 1)
      $display("FAIL d7_done: done@143=%b count=%0d want 1/1", done_s[143][4], done_count(4, 0, 146));
    else n_pass++;
    n_checks++;
    if (busy_s[144][4] !== 1'b0 || tx_s[144][4] !== 1'b1)
      $display("FAIL d7_idle: busy=%b tx=%b at 144 want 0/1", busy_s[144][4], tx_s[144][4]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    set_tick(1);
    launch(5'b00001, 8'hA5, 1'b0);
    capture(40, -1, -1);  // now inside data bit 1 of 0xA5 (a 0)
    n_checks++;
    if (tx_w[0] !== 1'b0 || busy_w[0] !== 1'b1)
      $display("FAIL midrst_before: tx=%b busy=%b want 0/1", tx_w[0], busy_w[0]);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0)
      $display("FAIL midrst_async: tx=%b busy=%b done=%b want 1/0/0", tx_w[0], busy_w[0], done_w[0]);
    else n_pass++;
    step(); step();
    reset = 1'b1;
    capture(200, -1, -1);
    bad = tx_bad(0, 0, 200, 1'b1);
    n_checks++;
    if (bad >= 0 || busy_bad(0, 0, 200, 1'b0) >= 0 || done_count(0, 0, 200) != 0)
      $display("FAIL midrst_aborted: tx/busy/done not idle after reset (tx_bad=%0d done=%0d) want idle",
               bad, done_count(0, 0, 200));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_default_frame();
    test_ignore_start();
    test_back_to_back();
    test_parity();
    test_sb32_dbit7();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
